// File: rtl/mark_call_pkg.sv
// Shared types and constants for the mark_for_codepoint call initiator.
package mark_call_pkg;

   localparam int CP_W = 32;

   typedef struct packed {
      logic [CP_W-1:0] cp;
      logic [CP_W-1:0] mark;
   } result_t;

endpackage

// File: rtl/mark_call_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
module mark_call_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             wr, rd;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rptr];

   // A push into a full FIFO is taken when the head leaves in the same cycle.
   assign rd = pop && !empty;
   assign wr = push && (!full || rd);

   always_ff @(posedge clock) begin
      if (wr) mem[wptr] <= din;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mark_call_initiator.sv
// Caller-side driver for mark_for_codepoint: issues calls, pairs returns
// with their codepoints in order, and streams {cp, mark} results.
module mark_call_initiator
   import mark_call_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 8,
   parameter int OUT_DEPTH       = 4,
   parameter int CNT_W           = 16
) (
   input  logic                               clock,
   input  logic                               resetn,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [CP_W-1:0]                    in_cp,
   output logic                               call_start,
   input  logic                               call_busy,
   output logic [CP_W-1:0]                    call_c,
   input  logic                               ret_done,
   output logic                               ret_stall,
   input  logic [CP_W-1:0]                    ret_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [CP_W-1:0]                    out_cp,
   output logic [CP_W-1:0]                    out_mark,
   output logic [$clog2(MAX_OUTSTANDING):0]   inflight,
   output logic [CNT_W-1:0]                   issued_cnt,
   output logic [CNT_W-1:0]                   done_cnt,
   output logic                               proto_err
);

   localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int OW = $clog2(OUT_DEPTH) + 1;

   logic [CP_W-1:0] head_cp;
   logic            if_full, if_empty;
   logic [IW-1:0]   if_count;
   result_t         res_in, res_out;
   logic            res_full, res_empty;
   logic [OW-1:0]   res_count;
   logic            credit_ok, call_acc, ret_acc, pair_ok, out_pop;

   // Reserve result-FIFO space for every call in flight so returns never stall.
   always_comb begin
      credit_ok = (32'(if_count) < 32'(MAX_OUTSTANDING)) &&
                  ((32'(if_count) + 32'(res_count)) < 32'(OUT_DEPTH));
   end

   assign call_start = resetn && in_valid && credit_ok;
   assign call_c     = in_cp;
   assign in_ready   = resetn && credit_ok && !call_busy;
   assign call_acc   = call_start && !call_busy && !if_full;

   assign ret_stall  = resetn && res_full;
   assign ret_acc    = resetn && ret_done && !res_full;
   assign pair_ok    = ret_acc && !if_empty;

   assign out_valid  = resetn && !res_empty;
   assign out_pop    = out_valid && out_ready;
   assign out_cp     = res_out.cp;
   assign out_mark   = res_out.mark;

   assign res_in.cp   = head_cp;
   assign res_in.mark = ret_data;
   assign inflight    = if_count;

   mark_call_fifo #(
      .WIDTH (CP_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_inflight (
      .clock  (clock),
      .resetn (resetn),
      .push   (call_acc),
      .din    (in_cp),
      .pop    (pair_ok),
      .dout   (head_cp),
      .count  (if_count),
      .full   (if_full),
      .empty  (if_empty)
   );

   mark_call_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (OUT_DEPTH)
   ) u_result (
      .clock  (clock),
      .resetn (resetn),
      .push   (pair_ok),
      .din    (res_in),
      .pop    (out_pop),
      .dout   (res_out),
      .count  (res_count),
      .full   (res_full),
      .empty  (res_empty)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         issued_cnt <= '0;
         done_cnt   <= '0;
         proto_err  <= 1'b0;
      end else begin
         if (call_acc) issued_cnt <= issued_cnt + 1'b1;
         if (ret_acc)  done_cnt   <= done_cnt + 1'b1;
         if (ret_acc && if_empty) proto_err <= 1'b1;
      end
   end

endmodule
